// File: rtl/bcd_feeder_pkg.sv
// Shared definitions for the binary-to-BCD display feeder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bcd_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          BCD_DIGITS = 8;
  localparam logic [31:0] MAX_DEC    = 32'd99_999_999;
  localparam logic [3:0]  OVF_DIGIT  = 4'hF;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_add3_digit (
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  // Pre-shift correction so the following left shift carries out at 10.
  always_comb begin
    corrected = (digit >= 4'd5) ? digit + 4'd3 : digit;
  end

endmodule

// File: rtl/bin_to_bcd_feeder.sv
// Sequential double-dabble converter feeding the 8-digit display; optional AUTO_CONVERT_EN launches on BinIn change.
// Latency: Done pulses IN_WIDTH+1 cycles after the launch edge, constant for all inputs.
// Backpressure: none; launch requests while Busy are dropped, results hold until the next Done.
module bin_to_bcd_feeder
  import bcd_feeder_pkg::*;
#(
  parameter int IN_WIDTH = 27,
  parameter int DIGITS   = BCD_DIGITS
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [IN_WIDTH-1:0] BinIn,
  input  logic                Start,
  output logic                Busy,
  output logic                Done,
  output logic                Ovf,
  output logic [15:0]         BcdLow,
  output logic [15:0]         BcdHigh
);

  localparam int ACC_W = DIGITS * 4;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  state_t              state;
  state_t              state_next;
  logic [IN_WIDTH-1:0] bin_q;
  logic [ACC_W-1:0]    bcd_q;
  logic [ACC_W-1:0]    bcd_adj;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_q;
  logic                launch;
  logic [31:0]         bin_ext;

  // Overflow is judged on the full input width, zero-extended.
  assign bin_ext = 32'(BinIn);

  // One correction block per digit; no carry crosses digit boundaries.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .digit     (bcd_q[g*4 +: 4]),
      .corrected (bcd_adj[g*4 +: 4])
    );
  end

`ifdef AUTO_CONVERT_EN
  logic [IN_WIDTH-1:0] last_q;

  // Launch whenever the input differs from the value last converted.
  assign launch = (state == IDLE) && (BinIn != last_q);

  // Remember the value captured by each launch.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      last_q <= '0;
    end else if (launch) begin
      last_q <= BinIn;
    end
  end
`else
  assign launch = (state == IDLE) && Start;
`endif

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: IDLE -> SHIFT on launch, SHIFT until last bit, one DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Busy covers every non-idle state.
  always_comb begin
    Busy = (state != IDLE);
  end

  // Datapath: capture, shift-add-3, and publish results in DONE.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      Done    <= 1'b0;
      Ovf     <= 1'b0;
      BcdLow  <= 16'h0000;
      BcdHigh <= 16'h0000;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            bin_q <= BinIn;
            bcd_q <= '0;
            cnt_q <= CNT_W'(IN_WIDTH);
            ovf_q <= (bin_ext > MAX_DEC);
          end
        end
        SHIFT: begin
          bcd_q <= {bcd_adj[ACC_W-2:0], bin_q[IN_WIDTH-1]};
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        DONE: begin
          BcdHigh <= ovf_q ? {4{OVF_DIGIT}} : bcd_q[31:16];
          BcdLow  <= ovf_q ? {4{OVF_DIGIT}} : bcd_q[15:0];
          Ovf     <= ovf_q;
          Done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_feeder.sv
// Bench for bin_to_bcd_feeder: decimal reference model feeding a result scoreboard.
// Latency: checks the fixed IN_WIDTH+1 cycle launch-to-Done delay.
// Backpressure: checks that launches during Busy are dropped.
module tb_bin_to_bcd_feeder;

  localparam int W = 27;

  typedef struct packed {
    logic [15:0] high;
    logic [15:0] low;
    logic        ovf;
  } exp_t;

  logic         Clk;
  logic         Rst_n;
  logic [W-1:0] BinIn;
  logic         Start;
  logic         Busy;
  logic         Done;
  logic         Ovf;
  logic [15:0]  BcdLow;
  logic [15:0]  BcdHigh;

  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  bin_to_bcd_feeder #(.IN_WIDTH(W)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .BinIn   (BinIn),
    .Start   (Start),
    .Busy    (Busy),
    .Done    (Done),
    .Ovf     (Ovf),
    .BcdLow  (BcdLow),
    .BcdHigh (BcdHigh)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: repeated division by ten, saturated to all-F above 8 digits.
  function automatic exp_t model(input int unsigned v);
    exp_t        e;
    logic [31:0] acc;
    int unsigned x;
    x = v;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      acc[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    if (v > 99_999_999) acc = 32'hFFFF_FFFF;
    e.high = acc[31:16];
    e.low  = acc[15:0];
    e.ovf  = (v > 99_999_999);
    return e;
  endfunction

  // Scoreboard: every Done must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (Rst_n && Done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("bcd_high", {16'h0, BcdHigh}, {16'h0, e.high});
        chk("bcd_low",  {16'h0, BcdLow},  {16'h0, e.low});
        chk("ovf",      {31'h0, Ovf},     {31'h0, e.ovf});
      end
    end
  end

  // Count cycles until Done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      n++;
      if (Done) return;
    end
    chk("done_timeout", 32'd1, 32'd0);
  endtask

  // One-cycle Start pulse; Busy must already be up the cycle after.
  task automatic launch(input int unsigned v, input bit push);
    @(negedge Clk);
    BinIn = W'(v);
    Start = 1'b1;
    if (push) sb.push_back(model(v));
    @(negedge Clk);
    Start = 1'b0;
    chk("busy_after_start", {31'h0, Busy}, 32'd1);
  endtask

  task automatic convert(input int unsigned v);
    int n;
    launch(v, 1'b1);
    wait_done(n);
    chk("latency", n, 32'd28);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    Rst_n = 1'b0;
    Start = 1'b0;
    BinIn = '0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", {31'h0, Busy}, 32'd0);
    chk("rst_done", {31'h0, Done}, 32'd0);
    chk("rst_ovf",  {31'h0, Ovf},  32'd0);
    chk("rst_bcd",  {BcdHigh, BcdLow}, 32'd0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

`ifdef AUTO_CONVERT_EN
    repeat (35) @(negedge Clk);
    chk("auto_idle_zero", done_cnt, 32'd0);
    BinIn = W'(7);
    sb.push_back(model(7));
    wait_done(n);
    chk("auto_latency", n, 32'd28);
    repeat (35) @(negedge Clk);
    chk("auto_hold", done_cnt, 32'd1);
    BinIn = W'(1000);
    sb.push_back(model(1000));
    wait_done(n);
    chk("auto_latency2", n, 32'd28);
    repeat (35) @(negedge Clk);
    chk("auto_total", done_cnt, 32'd2);
`else
    // Main function and boundaries.
    convert(12_345_678);
    convert(0);
    convert(99_999_999);
    convert(100_000_000);
    convert(55_050_505);

    // Second Start during a conversion is dropped.
    launch(24_681_357, 1'b1);
    repeat (4) @(negedge Clk);
    BinIn = W'(13_579_246);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    d0 = done_cnt;
    wait_done(n);
    repeat (35) @(negedge Clk);
    chk("single_done", done_cnt - d0, 32'd1);
    chk("idle_after", {31'h0, Busy}, 32'd0);

    // Reset mid-conversion aborts without Done.
    launch(87_654_321, 1'b0);
    repeat (9) @(negedge Clk);
    d0 = done_cnt;
    Rst_n = 1'b0;
    #1;
    chk("abort_bcd",  {BcdHigh, BcdLow}, 32'd0);
    chk("abort_busy", {31'h0, Busy}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (35) @(negedge Clk);
    chk("abort_no_done", done_cnt, d0);
    convert(87_654_321);

    // Start held high: back-to-back conversions every 29 cycles.
    @(negedge Clk);
    BinIn = W'(42);
    Start = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(model(42));
    wait_done(n);
    wait_done(n);
    chk("period1", n, 32'd29);
    wait_done(n);
    chk("period2", n, 32'd29);
    Start = 1'b0;
    repeat (35) @(negedge Clk);
`endif

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_feeder.md
Name: bin_to_bcd_feeder

Overview:
Sequential shift-add-3 (double-dabble) converter that turns an unsigned binary value into 8 packed BCD digits. It sits directly upstream of the 8-digit hex display driver: BcdLow drives the lower 4-digit input and BcdHigh drives the upper 4-digit input. Digits 0-9 therefore render as decimal. Out-of-range values are flagged and force every digit to 0xF.

Parameters:
IN_WIDTH, 27, width of BinIn; legal range 1..32.
DIGITS, 8, number of BCD digits produced; fixed at 8 for the display pairing. Output width is DIGITS*4 = 32 bits.

Ports:
Clk  input  1  system clock (100 MHz), all logic on posedge.
Rst_n  input  1  asynchronous, active-low reset.
BinIn  input  IN_WIDTH  unsigned binary value to convert.
Start  input  1  conversion request; sampled only in IDLE.
Busy  output  1  high while a conversion is in progress.
Done  output  1  one-cycle pulse when BcdLow/BcdHigh/Ovf update.
Ovf  output  1  last converted value exceeded 99_999_999.
BcdLow  output  16  BCD digits 3..0; digit 0 in bits [3:0].
BcdHigh  output  16  BCD digits 7..4; digit 4 in bits [3:0].

Behaviour:
- Reset (Rst_n=0, async assert): state=IDLE, Busy=0, Done=0, Ovf=0, BcdLow=16'h0000, BcdHigh=16'h0000. The shift register and counter are cleared.
- Reset release is synchronous to Clk. There is no activity until the first Start.
- States:
  - IDLE:
    - Start=1 at edge k latches BinIn into the binary shift register and clears the 32-bit BCD accumulator.
    - Also at edge k: sets the overflow flag ovf_q = (BinIn > 99_999_999), loads bit counter = IN_WIDTH, and moves to SHIFT.
  - SHIFT:
    - Each edge, every BCD digit >= 5 is first corrected by +3.
    - Then {bcd, bin} is shifted left by 1 and the counter is decremented.
    - When the counter goes 1->0, move to DONE.
    - Shifts occur at edges k+1 .. k+IN_WIDTH.
  - DONE (one cycle):
    - At edge k+IN_WIDTH+1, registers BcdHigh/BcdLow from the accumulator, or 16'hFFFF/16'hFFFF if ovf_q=1.
    - Ovf<=ovf_q, Done<=1 for exactly that cycle, then back to IDLE.
- Busy=1 in SHIFT and DONE states (from edge k+1 through the cycle before Done falls).
- Latency is constant: Done is seen IN_WIDTH+1 cycles after the Start sample edge, for overflowed inputs too.
- Start while Busy=1 is ignored and not queued.
- Start held high in IDLE restarts immediately: a back-to-back throughput of one conversion per IN_WIDTH+2 cycles.
- Outputs hold their last value between conversions. BinIn changes during SHIFT have no effect.
- Arithmetic:
  - The accumulator is 32 bits.
  - The add-3 is per 4-bit digit with no carry into the adjacent digit.
  - The overflow compare is done at full IN_WIDTH precision, zero-extended to 32 bits.
  - With IN_WIDTH <= 26, Ovf is always 0.
- Boundaries:
  - BinIn=0 gives 0x0000/0x0000.
  - 99_999_999 gives 0x9999/0x9999, Ovf=0.
  - 100_000_000 gives 0xFFFF/0xFFFF, Ovf=1.
- Reset mid-conversion aborts the conversion: no Done pulse, and outputs go to their reset values.

Optional Feature:
Macro AUTO_CONVERT_EN.
- Defined:
  - Start is ignored. An internal register last_q (reset 0) holds the most recently launched BinIn.
  - In IDLE, if BinIn != last_q, a conversion launches exactly as if Start=1 and last_q<=BinIn.
  - The first conversion after reset occurs only when BinIn != 0. Outputs already show 0 for BinIn = 0.
- Not defined: conversions launch only on Start. last_q does not exist.

Decomposition:
Shared package bcd_feeder_pkg:
- state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
- BCD_DIGITS=8
- MAX_DEC=32'd99_999_999
- OVF_DIGIT=4'hF

Natural sub-module: bcd_add3_digit, a combinational 4-bit in/out block computing (d>=5)?d+3:d. It is instantiated DIGITS times in a generate loop.

Test Plan:
- Reset, then Start with BinIn=12_345_678 (IN_WIDTH=27) -> Busy high next cycle. Done pulses exactly 28 cycles after the Start edge with BcdHigh=16'h1234, BcdLow=16'h5678, Ovf=0.
- Boundary values: BinIn=0 -> 0x0000/0x0000. BinIn=99_999_999 -> 0x9999/0x9999, Ovf=0. BinIn=100_000_000 -> 0xFFFF/0xFFFF, Ovf=1, same 28-cycle latency.
- Start=1 again 5 cycles into a conversion with a different BinIn -> ignored. The result matches the first value, with a single Done pulse.
- Rst_n pulsed low 10 cycles into a conversion of 87_654_321 -> outputs return to 0 immediately, with no Done. A subsequent Start converts to 0x8765/0x4321.
- Start held high with BinIn=42 -> Done every 29 cycles, each giving BcdLow=16'h0042, BcdHigh=16'h0000.
- With AUTO_CONVERT_EN: BinIn steps 0 -> 7 -> 7 -> 1000 with Start=0 -> exactly two Done pulses, results 0x0007 then 0x1000.
